fir_sample_sequencer: RTL and testbench

Front-end controller for `fir_filter`. Accepts audio samples on a valid/ready stream and writes them into a 128-entry circular sample RAM. It also owns the coefficient RAM, serving both RAMs to the filter through 1-cycle synchronous read ports. Each accepted sample launches one filter run; the 16-bit result is returned on a valid/ready output stream.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_sample_sequencer_if.sv | 28 ++
 rtl/fir_sample_sequencer_sdp_ram.sv | 25 ++
 rtl/fir_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_fir_sample_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR sample sequencer and its
// fir_filter integration.
package fir_pkg;
   localparam int ADDR_WIDTH  = 7;
   localparam int DATA_WIDTH  = 16;
   localparam int DEPTH       = 1 << ADDR_WIDTH;
   localparam int GUARD       = 3;
   localparam int GUARD_WIDTH = $clog2(GUARD);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_KICK,
      ST_RUN,
      ST_HOLD
   } seq_state_t;
endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Sample input stream, coefficient load port and result output stream of the
// FIR sample sequencer.
interface fir_sample_sequencer_if;
   import fir_pkg::*;

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;

   logic                  coef_we;
   logic [ADDR_WIDTH-1:0] coef_addr;
   logic [DATA_WIDTH-1:0] coef_data;
   logic                  coef_ready;

   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, coef_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, coef_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_sample_sequencer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle
// latency). rd_clr forces the read register to zero.
module sdp_ram #(
   parameter int AW = 7,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rd_clr,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rd_clr) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/fir_sample_sequencer.sv
// Front-end controller for fir_filter: circular sample buffer, coefficient RAM,
// one filter run per accepted sample, result returned on a valid/ready stream.
//
// state | meaning
// INIT  | clearing sample RAM, one entry per cycle
// IDLE  | accepting samples and coefficient writes
// KICK  | one-cycle fir_reset launch pulse
// RUN   | waiting for a qualified fir_done after the guard window
// HOLD  | result presented, waiting for out_ready
module fir_sample_sequencer
   import fir_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] taps_last,
   fir_sample_sequencer_if.slave bus,
   output logic                  fir_reset,
   output logic [ADDR_WIDTH-1:0] fir_start_addr,
   output logic [ADDR_WIDTH-1:0] fir_last_addr,
   input  logic                  fir_done,
   input  logic [DATA_WIDTH-1:0] fir_result,
   input  logic [ADDR_WIDTH-1:0] fir_audio_addr,
   output logic [DATA_WIDTH-1:0] fir_audio_data,
   input  logic [ADDR_WIDTH-1:0] fir_kernel_addr,
   output logic [DATA_WIDTH-1:0] fir_kernel_data
);
   seq_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0]  init_cnt, wr_ptr, len_r, start_r;
   logic [ADDR_WIDTH-1:0]  wr_eff, wr_next;
   logic [GUARD_WIDTH-1:0] guard_cnt;
   logic                   guard_done;
   logic                   out_valid_r;
   logic [DATA_WIDTH-1:0]  out_data_r;
   logic                   in_ready_c, coef_ready_c, kick_c;
   logic                   accept, capture, hold_ack;
   logic                   smp_we, coef_we, rd_clr;
   logic [ADDR_WIDTH-1:0]  smp_waddr;
   logic [DATA_WIDTH-1:0]  smp_wdata;

   // The KICK cycle is the first guard cycle, so done is first honoured at launch+GUARD.
   assign guard_done = (guard_cnt == GUARD_WIDTH'(GUARD - 1));
   assign wr_eff     = (wr_ptr > taps_last) ? '0 : wr_ptr;
   assign wr_next    = (wr_eff == taps_last) ? '0 : wr_eff + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      in_ready_c   = 1'b0;
      coef_ready_c = 1'b0;
      kick_c       = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      hold_ack     = 1'b0;
      case (state)
         ST_INIT: if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_IDLE;
         ST_IDLE: begin
            in_ready_c   = 1'b1;
            coef_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_KICK;
            end
         end
         ST_KICK: begin
            kick_c    = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: if (fir_done && guard_done) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
         end
         ST_HOLD: if (bus.out_ready) begin
            hold_ack  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_cnt    <= '0;
         wr_ptr      <= '0;
         len_r       <= '0;
         start_r     <= '0;
         guard_cnt   <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else begin
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
         if (accept) begin
            len_r   <= taps_last;
            wr_ptr  <= wr_next;
            start_r <= wr_next;
         end
         if (state == ST_KICK) guard_cnt <= '0;
         else if (state == ST_RUN && !guard_done) guard_cnt <= guard_cnt + 1'b1;
         if (capture) begin
            out_data_r  <= fir_result;
            out_valid_r <= 1'b1;
         end else if (hold_ack) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign smp_we    = !reset && ((state == ST_INIT) || accept);
   assign smp_waddr = (state == ST_INIT) ? init_cnt : wr_eff;
   assign smp_wdata = (state == ST_INIT) ? '0 : bus.in_data;
   assign coef_we   = !reset && bus.coef_we && coef_ready_c;
   // Read registers stay zero through INIT so a stale filter run sees nothing.
   assign rd_clr    = reset || (state == ST_INIT);

   sdp_ram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_sample_ram (
      .clk     (clk),
      .rd_clr  (rd_clr),
      .we      (smp_we),
      .wr_addr (smp_waddr),
      .wr_data (smp_wdata),
      .rd_addr (fir_audio_addr),
      .rd_data (fir_audio_data)
   );

   sdp_ram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_coef_ram (
      .clk     (clk),
      .rd_clr  (rd_clr),
      .we      (coef_we),
      .wr_addr (bus.coef_addr),
      .wr_data (bus.coef_data),
      .rd_addr (fir_kernel_addr),
      .rd_data (fir_kernel_data)
   );

   assign bus.in_ready   = in_ready_c;
   assign bus.coef_ready = coef_ready_c;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = out_data_r;
   assign fir_reset      = kick_c;
   assign fir_start_addr = start_r;
   assign fir_last_addr  = len_r;
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: behavioural fir_filter stand-in, reference
// model of the circular buffer and convolution, scoreboard-driven output checks.
module tb_fir_sample_sequencer;
   import fir_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [ADDR_WIDTH-1:0] taps_last = '0;
   logic                  fir_reset;
   logic [ADDR_WIDTH-1:0] fir_start_addr, fir_last_addr;
   logic                  fir_done;
   logic [DATA_WIDTH-1:0] fir_result;
   logic [ADDR_WIDTH-1:0] fir_audio_addr, fir_kernel_addr;
   logic [DATA_WIDTH-1:0] fir_audio_data, fir_kernel_data;

   fir_sample_sequencer_if bus();

   fir_sample_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .taps_last       (taps_last),
      .bus             (bus),
      .fir_reset       (fir_reset),
      .fir_start_addr  (fir_start_addr),
      .fir_last_addr   (fir_last_addr),
      .fir_done        (fir_done),
      .fir_result      (fir_result),
      .fir_audio_addr  (fir_audio_addr),
      .fir_audio_data  (fir_audio_data),
      .fir_kernel_addr (fir_kernel_addr),
      .fir_kernel_data (fir_kernel_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] m_mem  [DEPTH];
   logic [15:0] m_coef [DEPTH];
   int          m_wp = 0;
   logic [15:0] exp_q [$];
   int          lat_q [$];
   int          ready_mode = 0;
   logic        mon_pv = 1'b0, mon_pr = 1'b0;
   logic [15:0] mon_pd = '0;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Coefficient k weights the k-th oldest of the last n samples.
   function automatic logic [15:0] model_out(input int n);
      longint acc = 0;
      for (int k = 0; k < n; k++)
         acc += longint'($signed(m_coef[k])) * longint'($signed(m_mem[(m_wp + k) % n]));
      return 16'(acc >>> 16);
   endfunction

   // Filter stand-in: reads addresses A+2..A+N+1, done at A+N+3, holds done until relaunch.
   initial begin : filter_model
      int n;
      logic [6:0] a, last;
      longint acc;
      fir_done = 1'b0; fir_result = '0; fir_audio_addr = '0; fir_kernel_addr = '0;
      forever begin
         @(negedge clk);
         if (fir_reset === 1'b1) begin
            fir_done = 1'b0;
            last = fir_last_addr;
            a    = fir_start_addr;
            n    = int'(last) + 1;
            acc  = 0;
            for (int i = 0; i <= n; i++) begin
               @(posedge clk); #1;
               if (i > 0)
                  acc += longint'($signed(fir_audio_data)) * longint'($signed(fir_kernel_data));
               if (n == 1) begin
                  if (i == 0) begin fir_done = 1'b1; fir_result = 16'hDEAD; end
                  else fir_done = 1'b0;
               end
               if (i < n) begin
                  fir_audio_addr  = a;
                  fir_kernel_addr = 7'(i);
                  a = (a == last) ? 7'd0 : a + 7'd1;
               end
            end
            @(posedge clk); #1;
            fir_result = 16'(acc >>> 16);
            fir_done   = 1'b1;
         end
      end
   end

   initial begin : ready_driver
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_pv = 1'b0; mon_pr = 1'b0;
         end else begin
            if (bus.out_valid === 1'b1 && !mon_pv) begin
               if (lat_q.size() == 0) check("unexpected_out_valid", 1, 0);
               else                   check("out_latency", cyc, lat_q.pop_front());
            end
            if (mon_pv && !mon_pr) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_data", bus.out_data, mon_pd);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
               if (exp_q.size() == 0) check("unexpected_output", 1, 0);
               else                   check("out_data", bus.out_data, exp_q.pop_front());
            end
            mon_pv = bus.out_valid; mon_pr = bus.out_ready; mon_pd = bus.out_data;
         end
      end
   end

   task automatic do_reset();
      int viol_rdy, viol_out;
      @(posedge clk); #1;
      reset = 1'b1; bus.in_valid = 1'b0; bus.coef_we = 1'b0;
      exp_q.delete(); lat_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      m_wp = 0;
      viol_rdy = 0; viol_out = 0;
      @(negedge clk);
      check("out_valid_after_reset", bus.out_valid, 0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i > 0) @(negedge clk);
         if (bus.in_ready !== 1'b0) viol_rdy++;
         if (bus.coef_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
             fir_reset !== 1'b0 || fir_start_addr !== '0 || fir_last_addr !== '0 ||
             fir_audio_data !== '0 || fir_kernel_data !== '0) viol_out++;
      end
      check("init_ready_low", viol_rdy, 0);
      check("init_outputs_zero", viol_out, 0);
      @(negedge clk);
      check("init_ready_rise", bus.in_ready, 1);
   endtask

   task automatic write_coef(input logic [6:0] addr, input logic [15:0] data);
      @(posedge clk); #1;
      bus.coef_we = 1'b1; bus.coef_addr = addr; bus.coef_data = data;
      @(negedge clk);
      check("coef_ready", bus.coef_ready, 1);
      m_coef[addr] = data;
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] d, input bit use_lit, input logic [15:0] lit);
      int w, n, wp;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = d;
      w = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && w < 400) begin @(negedge clk); w++; end
      if (bus.in_ready !== 1'b1) begin
         check("in_ready_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      n  = int'(taps_last) + 1;
      wp = (m_wp > int'(taps_last)) ? 0 : m_wp;
      m_mem[wp] = d;
      m_wp = (wp == int'(taps_last)) ? 0 : wp + 1;
      exp_q.push_back(use_lit ? lit : model_out(n));
      lat_q.push_back(cyc + n + 4);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("fir_reset_pulse", fir_reset, 1);
      check("start_addr", fir_start_addr, m_wp);
      check("last_addr", fir_last_addr, taps_last);
      @(negedge clk);
      check("fir_reset_width", fir_reset, 0);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 1000) begin @(negedge clk); w++; end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      bad++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin : stimulus
      int w, viol;
      bus.in_valid = 1'b0; bus.in_data = '0;
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
      for (int k = 0; k < DEPTH; k++) begin m_mem[k] = '0; m_coef[k] = '0; end
      do_reset();

      // Impulse through 4 taps, then wrap of the start address.
      taps_last = 7'd3;
      for (int k = 0; k < 4; k++) write_coef(7'(k), 16'h4000);
      send_sample(16'h7FFF, 1'b1, 16'h1FFF);
      for (int k = 0; k < 3; k++) send_sample(16'h0000, 1'b1, 16'h1FFF);
      send_sample(16'h0000, 1'b1, 16'h0000);
      send_sample(16'h0000, 1'b1, 16'h0000);
      drain();

      // Single tap: early spurious done must be masked.
      taps_last = 7'd0;
      write_coef(7'd0, 16'h4000);
      send_sample(16'h2000, 1'b1, 16'h0800);
      drain();

      // Backpressure: held result, blocked input, ignored coefficient write.
      taps_last = 7'd3;
      ready_mode = 2;
      send_sample(16'h1234, 1'b0, '0);
      w = 0;
      while (bus.out_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      check("hold_reached", bus.out_valid, 1);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus.coef_we = 1'b1; bus.coef_addr = 7'd2; bus.coef_data = 16'h7FFF;
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.coef_ready !== 1'b0) viol++;
      end
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      check("hold_ports_blocked", viol, 0);
      ready_mode = 0;
      drain();
      send_sample(16'h4000, 1'b0, '0);
      drain();

      // Randomised coefficients, samples, tap counts and output backpressure.
      for (int k = 0; k < DEPTH; k++) write_coef(7'(k), 16'($urandom));
      ready_mode = 1;
      for (int i = 0; i < 30; i++) begin
         taps_last = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
         send_sample(16'($urandom), 1'b0, '0);
      end
      drain();
      ready_mode = 0;

      // Reset during RUN aborts the run; the next result sees only the new sample.
      taps_last = 7'd3;
      send_sample(16'h5555, 1'b0, '0);
      do_reset();
      taps_last = 7'd3;
      send_sample(16'h4000, 1'b0, '0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
